// File: rtl/signal_sequencer.sv
// signal_sequencer: plays a small table of waveform segments into the DAC
// signal generator, switching segment only at generator period boundaries.
module signal_sequencer #(
    parameter int SEQ_DEPTH    = 8,
    parameter int ADDR_WIDTH   = 3,
    parameter int AMP_WIDTH    = 16,
    parameter int PINC_WIDTH   = 16,
    parameter int REPEAT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [3:0]              wr_type,
    input  logic [AMP_WIDTH-1:0]    wr_amp,
    input  logic [PINC_WIDTH-1:0]   wr_pinc,
    input  logic [REPEAT_WIDTH-1:0] wr_repeat,
    input  logic [ADDR_WIDTH:0]     seq_length,
    input  logic                    loop_en,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    period_wrap,
    output logic [3:0]              cfg_type,
    output logic [AMP_WIDTH-1:0]    cfg_amp,
    output logic [PINC_WIDTH-1:0]   cfg_pinc,
    output logic                    cfg_update,
    output logic                    gen_enable,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   seg_index,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(SEQ_DEPTH);

    logic [3:0]              tbl_type   [SEQ_DEPTH];
    logic [AMP_WIDTH-1:0]    tbl_amp    [SEQ_DEPTH];
    logic [PINC_WIDTH-1:0]   tbl_pinc   [SEQ_DEPTH];
    logic [REPEAT_WIDTH-1:0] tbl_repeat [SEQ_DEPTH];

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   seg_next;
    logic [REPEAT_WIDTH-1:0] rep_cnt;
    logic [REPEAT_WIDTH-1:0] rep_load;
    logic [ADDR_WIDTH:0]     len_cap;
    logic [ADDR_WIDTH:0]     last_idx;
    logic                    loop_cap;
    logic                    start_ok;
    logic                    at_last;
    logic                    capture;
    logic                    load_now;
    logic                    rep_dec;
    logic                    gen_next;

    // Table is a plain register file: no reset, writable in every state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl_type[wr_addr]   <= wr_type;
            tbl_amp[wr_addr]    <= wr_amp;
            tbl_pinc[wr_addr]   <= wr_pinc;
            tbl_repeat[wr_addr] <= wr_repeat;
        end
    end

    assign start_ok = start && (seq_length != '0) && (seq_length <= DEPTH_LEN);
    assign last_idx = len_cap - (ADDR_WIDTH+1)'(1);
    assign at_last  = ({1'b0, seg_index} >= last_idx);
    assign rep_load = (tbl_repeat[seg_index] == '0) ? REPEAT_WIDTH'(1)
                                                    : tbl_repeat[seg_index];

    // stop outranks period_wrap, which outranks start.
    always_comb begin
        state_next = state;
        seg_next   = seg_index;
        capture    = 1'b0;
        rep_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!stop && start_ok) begin
                    state_next = LOAD;
                    seg_next   = '0;
                    capture    = 1'b1;
                end
            end
            LOAD: begin
                state_next = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (period_wrap) begin
                    if (rep_cnt > REPEAT_WIDTH'(1)) begin
                        rep_dec = 1'b1;
                    end else if (!at_last) begin
                        seg_next   = seg_index + ADDR_WIDTH'(1);
                        state_next = LOAD;
                    end else if (loop_cap) begin
                        seg_next   = '0;
                        state_next = LOAD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        load_now = (state == LOAD) && !stop;
        // The generator keeps running through the LOAD of a segment change,
        // but not through the very first LOAD after start.
        gen_next = (state_next == RUN) || ((state_next == LOAD) && (state == RUN));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            seg_index  <= '0;
            rep_cnt    <= '0;
            len_cap    <= '0;
            loop_cap   <= 1'b0;
            cfg_type   <= '0;
            cfg_amp    <= '0;
            cfg_pinc   <= '0;
            cfg_update <= 1'b0;
            gen_enable <= 1'b0;
        end else begin
            state      <= state_next;
            seg_index  <= seg_next;
            cfg_update <= load_now;
            gen_enable <= gen_next;
            if (capture) begin
                len_cap  <= seq_length;
                loop_cap <= loop_en;
            end
            if (load_now) begin
                cfg_type <= tbl_type[seg_index];
                cfg_amp  <= tbl_amp[seg_index];
                cfg_pinc <= tbl_pinc[seg_index];
                rep_cnt  <= rep_load;
            end else if (rep_dec) begin
                rep_cnt <= rep_cnt - REPEAT_WIDTH'(1);
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_signal_sequencer.sv
// Directed bench for signal_sequencer: a table of per-cycle vectors for basic
// playback plus hand-written sequences for looping, abort and corner cases.
module tb_signal_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_type;
    logic [15:0] wr_amp;
    logic [15:0] wr_pinc;
    logic [15:0] wr_repeat;
    logic [3:0]  seq_length;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        period_wrap;
    logic [3:0]  cfg_type;
    logic [15:0] cfg_amp;
    logic [15:0] cfg_pinc;
    logic        cfg_update;
    logic        gen_enable;
    logic        busy;
    logic [2:0]  seg_index;
    logic        done;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        wrap;
        logic [42:0] expect_out;
    } vec_t;

    vec_t vecs[10];

    signal_sequencer dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_type(wr_type), .wr_amp(wr_amp),
        .wr_pinc(wr_pinc), .wr_repeat(wr_repeat),
        .seq_length(seq_length), .loop_en(loop_en),
        .start(start), .stop(stop), .period_wrap(period_wrap),
        .cfg_type(cfg_type), .cfg_amp(cfg_amp), .cfg_pinc(cfg_pinc),
        .cfg_update(cfg_update), .gen_enable(gen_enable), .busy(busy),
        .seg_index(seg_index), .done(done)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cfg_update) upd_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [42:0] outs(logic b, logic g, logic u, logic d,
                                         logic [2:0] i, logic [3:0] t,
                                         logic [15:0] a, logic [15:0] p);
        return {b, g, u, d, i, t, a, p};
    endfunction

    function automatic logic [42:0] dutOuts();
        return {busy, gen_enable, cfg_update, done, seg_index, cfg_type, cfg_amp, cfg_pinc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start       = v.start;
        stop        = v.stop;
        period_wrap = v.wrap;
        tick();
        start       = 1'b0;
        stop        = 1'b0;
        period_wrap = 1'b0;
    endtask

    task automatic writeEntry(input logic [2:0] a, input logic [3:0] t, input logic [15:0] amp,
                              input logic [15:0] p, input logic [15:0] r);
        wr_addr = a; wr_type = t; wr_amp = amp; wr_pinc = p; wr_repeat = r;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int upd0, done0;
        logic [2:0] loop_idx [6];

        loop_idx[0] = 3'd0; loop_idx[1] = 3'd1; loop_idx[2] = 3'd0;
        loop_idx[3] = 3'd0; loop_idx[4] = 3'd1; loop_idx[5] = 3'd0;

        // Basic playback: entry0 {1,8191,10,2}, entry1 {2,4000,20,1}, length 2, no loop.
        vecs[0] = '{1'b1, 1'b0, 1'b0, outs(1, 0, 0, 0, 3'd0, 4'd0, 16'd0,    16'd0)};
        vecs[1] = '{1'b0, 1'b0, 1'b0, outs(1, 1, 1, 0, 3'd0, 4'd1, 16'd8191, 16'd10)};
        vecs[2] = '{1'b0, 1'b0, 1'b0, outs(1, 1, 0, 0, 3'd0, 4'd1, 16'd8191, 16'd10)};
        vecs[3] = '{1'b0, 1'b0, 1'b1, outs(1, 1, 0, 0, 3'd0, 4'd1, 16'd8191, 16'd10)};
        vecs[4] = '{1'b1, 1'b0, 1'b0, outs(1, 1, 0, 0, 3'd0, 4'd1, 16'd8191, 16'd10)};
        vecs[5] = '{1'b0, 1'b0, 1'b1, outs(1, 1, 0, 0, 3'd1, 4'd1, 16'd8191, 16'd10)};
        vecs[6] = '{1'b0, 1'b0, 1'b0, outs(1, 1, 1, 0, 3'd1, 4'd2, 16'd4000, 16'd20)};
        vecs[7] = '{1'b0, 1'b0, 1'b1, outs(1, 0, 0, 1, 3'd1, 4'd2, 16'd4000, 16'd20)};
        vecs[8] = '{1'b0, 1'b0, 1'b0, outs(0, 0, 0, 0, 3'd1, 4'd2, 16'd4000, 16'd20)};
        vecs[9] = '{1'b0, 1'b0, 1'b1, outs(0, 0, 0, 0, 3'd1, 4'd2, 16'd4000, 16'd20)};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_type = '0; wr_amp = '0;
        wr_pinc = '0; wr_repeat = '0; seq_length = '0; loop_en = 1'b0;
        start = 1'b0; stop = 1'b0; period_wrap = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_state", 64'(dutOuts()), 64'(outs(0, 0, 0, 0, 3'd0, 4'd0, 16'd0, 16'd0)));

        writeEntry(3'd0, 4'd1, 16'd8191, 16'd10, 16'd2);
        writeEntry(3'd1, 4'd2, 16'd4000, 16'd20, 16'd1);
        seq_length = 4'd2;
        loop_en    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), 64'(dutOuts()), 64'(vecs[i].expect_out));
        end

        // Looping over the same two entries.
        $display("[TB] looping sequence");
        loop_en = 1'b1;
        upd0 = upd_cnt; done0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int k = 0; k < 6; k++) begin
            period_wrap = 1'b1; tick(); period_wrap = 1'b0;
            tick(); tick();
            checkOutput($sformatf("loop_idx%0d", k), 64'(seg_index), 64'(loop_idx[k]));
            checkOutput($sformatf("loop_gen%0d", k), 64'(gen_enable), 64'(1));
        end
        checkOutput("loop_updates", 64'(upd_cnt - upd0), 64'(5));
        checkOutput("loop_no_done", 64'(done_cnt - done0), 64'(0));
        stop = 1'b1; tick(); stop = 1'b0;
        checkOutput("loop_stop", 64'({busy, gen_enable}), 64'(0));

        // Write collision during LOAD on a 1-entry looping sequence.
        $display("[TB] write collision and abort");
        writeEntry(3'd0, 4'd3, 16'd100, 16'd5, 16'd1);
        seq_length = 4'd1;
        loop_en    = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wr_addr = 3'd0; wr_type = 4'd1; wr_amp = 16'd200; wr_pinc = 16'd7; wr_repeat = 16'd1;
        wr_en = 1'b1; tick(); wr_en = 1'b0;
        checkOutput("collide_old", 64'({cfg_update, cfg_type, cfg_amp, cfg_pinc}),
                    64'({1'b1, 4'd3, 16'd100, 16'd5}));
        period_wrap = 1'b1; tick(); period_wrap = 1'b0; tick();
        checkOutput("collide_new", 64'({cfg_update, cfg_type, cfg_amp, cfg_pinc}),
                    64'({1'b1, 4'd1, 16'd200, 16'd7}));
        tick();
        upd0 = upd_cnt; done0 = done_cnt;
        stop = 1'b1; period_wrap = 1'b1; tick(); stop = 1'b0; period_wrap = 1'b0;
        checkOutput("abort_outs", 64'({busy, gen_enable, cfg_type, cfg_amp, cfg_pinc}),
                    64'({1'b0, 1'b0, 4'd1, 16'd200, 16'd7}));
        tick();
        checkOutput("abort_no_update", 64'(upd_cnt - upd0), 64'(0));
        checkOutput("abort_no_done", 64'(done_cnt - done0), 64'(0));

        // Repeat count of zero behaves as one.
        $display("[TB] repeat zero");
        writeEntry(3'd0, 4'd2, 16'd555, 16'd9, 16'd0);
        seq_length = 4'd1;
        loop_en    = 1'b0;
        start = 1'b1; tick(); start = 1'b0; tick();
        checkOutput("rep0_run", 64'({gen_enable, cfg_type, cfg_amp}), 64'({1'b1, 4'd2, 16'd555}));
        period_wrap = 1'b1; tick(); period_wrap = 1'b0;
        checkOutput("rep0_done", 64'({done, gen_enable, busy}), 64'({1'b1, 1'b0, 1'b1}));
        tick();
        checkOutput("rep0_idle", 64'({done, busy}), 64'(0));

        // Starts that must be ignored.
        $display("[TB] ignored starts");
        seq_length = 4'd0; start = 1'b1; tick(); start = 1'b0;
        checkOutput("start_len0", 64'({busy, gen_enable}), 64'(0));
        seq_length = 4'd9; start = 1'b1; tick(); start = 1'b0;
        checkOutput("start_len9", 64'({busy, gen_enable}), 64'(0));
        seq_length = 4'd1; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        checkOutput("start_with_stop", 64'({busy, gen_enable}), 64'(0));
        tick();
        checkOutput("still_idle", 64'({busy, cfg_update}), 64'(0));

        // Reset in the middle of a run.
        $display("[TB] reset during run");
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        checkOutput("pre_reset_run", 64'({busy, gen_enable}), 64'({1'b1, 1'b1}));
        reset = 1'b1; tick(); reset = 1'b0;
        checkOutput("reset_in_run", 64'(dutOuts()), 64'(outs(0, 0, 0, 0, 3'd0, 4'd0, 16'd0, 16'd0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signal_sequencer.md
# signal_sequencer

Sequencer in front of the DAC signal generator. It holds a small table of waveform segments, each with signal type, amplitude, phase increment and repeat count. It plays them in order by driving the generator's configuration inputs, and switches segment only at generator period boundaries. Configuration comes from the PS-side register map; `period_wrap` comes from the generator's phase accumulator.

## Interface
Parameters:
- `SEQ_DEPTH`, 8, number of table entries; power of two.
- `ADDR_WIDTH`, 3, log2(`SEQ_DEPTH`).
- `AMP_WIDTH`, 16, amplitude field width.
- `PINC_WIDTH`, 16, phase-increment field width.
- `REPEAT_WIDTH`, 16, repeat-count field width.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in `ADDR_WIDTH`: table entry to write.
- `wr_type` in 4: signal type (1 trapezoid, 2 triangle, 3 sawtooth).
- `wr_amp` in `AMP_WIDTH`: amplitude.
- `wr_pinc` in `PINC_WIDTH`: phase increment per clock.
- `wr_repeat` in `REPEAT_WIDTH`: generator periods per segment; 0 is treated as 1.
- `seq_length` in `ADDR_WIDTH+1`: number of entries to play, 1..`SEQ_DEPTH`.
- `loop_en` in 1: restart at entry 0 after the last entry.
- `start` in 1: pulse; begins playback.
- `stop` in 1: pulse; aborts playback.
- `period_wrap` in 1: one-cycle pulse from the generator at each phase wrap.
- `cfg_type` out 4: type presented to the generator.
- `cfg_amp` out `AMP_WIDTH`: amplitude presented to the generator.
- `cfg_pinc` out `PINC_WIDTH`: phase increment presented to the generator.
- `cfg_update` out 1: one-cycle pulse; the generator latches the `cfg_*` outputs on it.
- `gen_enable` out 1: generator run enable.
- `busy` out 1: high whenever the state is not IDLE.
- `seg_index` out `ADDR_WIDTH`: index of the active entry.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- **Table**
  - `SEQ_DEPTH` x (4+`AMP_WIDTH`+`PINC_WIDTH`+`REPEAT_WIDTH`) register file; contents are not cleared by reset.
  - Writes are accepted in every state.
  - A LOAD that reads the entry being written in the same cycle gets the old contents.
- **Start-time capture:** `seq_length` and `loop_en` are captured at `start`. Later changes have no effect until the next `start`.
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `gen_enable`=0.
  - `start`=1 with `seq_length`≠0 → LOAD, `seg_index`=0.
  - `start` with `seq_length`=0 or `seq_length`>`SEQ_DEPTH` is ignored.
- **LOAD**
  - Reads entry `seg_index` into `cfg_*`.
  - Loads the repeat counter with max(`repeat`,1).
  - Next state is RUN.
- **RUN** (`gen_enable`=1), on `period_wrap`:
  - Counter >1: decrement the counter.
  - Counter =1 and `seg_index` < captured length−1: `seg_index`+1, → LOAD.
  - Counter =1, last entry, loop enabled: `seg_index`=0, → LOAD.
  - Counter =1, last entry, loop disabled: → DONE.
- **DONE**
  - `gen_enable`=0.
  - `done`=1 for exactly one cycle.
  - Next state is IDLE.
- **stop**
  - From LOAD/RUN/DONE: → IDLE next cycle.
  - `gen_enable` drops, no `done` pulse.
  - `cfg_*` outputs hold their last values.
- **Priorities**
  - `reset` > `stop` > `period_wrap` > `start`.
  - `start` while busy is ignored.
  - `start`+`stop` in the same cycle in IDLE: stays IDLE.
- `period_wrap` is ignored outside RUN, including during the LOAD cycle.

## Timing
- **Reset values:** `cfg_type`=0, `cfg_amp`=0, `cfg_pinc`=0, `cfg_update`=0, `gen_enable`=0, `busy`=0, `seg_index`=0, `done`=0, state IDLE.
- **Start:** `start` sampled at edge T → state LOAD after T.
  - After edge T+1: `cfg_*` valid, `cfg_update`=1 for one cycle, `gen_enable`=1, state RUN.
  - `busy` goes high after edge T.
- **Segment change:** final `period_wrap` sampled at edge W → LOAD after W → new `cfg_*` and `cfg_update` after W+1.
  - The generator runs the old config for those 2 cycles.
  - `gen_enable` stays 1 across segment changes.
- **Completion:** final `period_wrap` of a non-looping sequence at edge W → state DONE after W.
  - `done`=1 and `gen_enable`=0 during cycle W+1.
  - IDLE and `busy`=0 after W+1.
- **Stop:** `stop` at edge S → `gen_enable`=0, `busy`=0 after S.
- **Pulse widths:** `cfg_update` is exactly one cycle per LOAD; a 1-entry looping sequence pulses it once per repeat block.

## Test plan
- **Basic playback:** reset; write entry0 = {1, 8191, 10, 2}, entry1 = {2, 4000, 20, 1}; `seq_length`=2, `loop_en`=0; pulse `start`; 3 `period_wrap`s → `cfg_update` pulses 2 cycles after `start` (entry0 values) and 2 cycles after the 2nd wrap (entry1 values); `done` 1 cycle after the 3rd wrap; `gen_enable` high for the whole run.
- **Looping:** same table, `loop_en`=1; 6 wraps → `seg_index` sequence 0,0→1→0,0→1; `done` never asserted.
- **Abort:** `stop` mid-RUN together with `period_wrap` → IDLE next cycle, `busy`=0, no `done`, no `cfg_update`, `cfg_*` unchanged.
- **Repeat zero:** entry `repeat`=0, `seq_length`=1 → completes after 1 wrap.
- **Ignored starts:** `start` with `seq_length`=0 stays IDLE; `start` with `seq_length`=9 stays IDLE; `start` during RUN has no effect.
- **Write collision and reset:** a write to the active entry during LOAD still yields the old values, and the new values on the next loop; `reset` asserted during RUN → all outputs at reset values next cycle.
